// File: rtl/s_pl_pkg.sv
// ---------------------------------------------------------------------------
// s_pl_pkg
// Shared definitions for the pipelined round-robin arbiter (s_pl_arb_nclk)
// and its combinational grant search (s_rr_arb).
//   clog2     : ceiling log2, used to derive requester id widths
//   MAX_NREQ  : largest supported requester count
// ---------------------------------------------------------------------------
package s_pl_pkg;

    localparam int MAX_NREQ = 16;

    // Ceiling log2 with a floor of 1 bit so a 1-wide id is never 0 bits.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/s_rr_arb.sv
// ---------------------------------------------------------------------------
// s_rr_arb
// Combinational round-robin grant search. Picks the first asserted request
// starting at ptr and moving upward with wrap-around.
//   req  in   NREQ  request vector
//   ptr  in   IDW   search start index (always < NREQ)
//   en   in   1     0 forces no grant
//   gnt  out  NREQ  one-hot grant (all zero when nothing granted)
//   gid  out  IDW   binary index of the granted requester (0 when none)
// ---------------------------------------------------------------------------
module s_rr_arb
    import s_pl_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gid
);

    logic found;
    int   idx;

    always_comb begin
        gnt   = '0;
        gid   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (en && !found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gid      = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/s_pl_arb_nclk.sv
// ---------------------------------------------------------------------------
// s_pl_arb_nclk
// Round-robin arbiter feeding one shared DELAY-stage pipeline. Each cycle at
// most one requester is granted; its word is tagged with the requester id and
// leaves the pipe tail DELAY cycles after the grant cycle.
//   clk       in   1          clock
//   rst       in   1          synchronous reset, active-high
//   stall     in   1          freeze pipe and pointer, no grants
//   flush     in   1          kill every in-flight word, no grants
//   req_vld   in   NREQ       per-requester request, held until granted
//   req_dat   in   NREQ*SIZE  requester i word at [i*SIZE +: SIZE]
//   req_gnt   out  NREQ       one-hot grant, same cycle as capture
//   odat_vld  out  1          tail stage valid
//   odat      out  SIZE       tail stage data
//   oid       out  IDW        requester id of tail word
//   busy      out  1          any stage valid
// ---------------------------------------------------------------------------
module s_pl_arb_nclk
    import s_pl_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int SIZE  = 8,
    parameter  int DELAY = 3,
    localparam int IDW   = clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 flush,
    input  logic [NREQ-1:0]      req_vld,
    input  logic [NREQ*SIZE-1:0] req_dat,
    output logic [NREQ-1:0]      req_gnt,
    output logic                 odat_vld,
    output logic [SIZE-1:0]      odat,
    output logic [IDW-1:0]       oid,
    output logic                 busy
);

    if (DELAY < 1 || NREQ < 2 || NREQ > MAX_NREQ) begin : g_bad_param
        $error("s_pl_arb_nclk: illegal parameters (DELAY>=1, 2<=NREQ<=16)");
    end

    logic [DELAY-1:0]           vld_q;
    logic [DELAY-1:0][IDW-1:0]  id_q;
    logic [DELAY-1:0][SIZE-1:0] dat_q;
    logic [IDW-1:0]             ptr_q, ptr_d;

    logic                       arb_en;
    logic                       any_gnt;
    logic [IDW-1:0]             gid;
    logic [SIZE-1:0]            sel_dat;

    // Control priority is rst > flush > stall; any of them blocks the grant.
    assign arb_en = !(rst || stall || flush);

    s_rr_arb #(.NREQ(NREQ)) u_arb (
        .req (req_vld),
        .ptr (ptr_q),
        .en  (arb_en),
        .gnt (req_gnt),
        .gid (gid)
    );

    assign any_gnt = |req_gnt;

    always_comb begin
        sel_dat = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gid == IDW'(i)) sel_dat = req_dat[i*SIZE +: SIZE];
        end
    end

    // Pointer moves just past the winner; any_gnt is already 0 under stall/flush.
    always_comb begin
        ptr_d = ptr_q;
        if (any_gnt) ptr_d = (gid == IDW'(NREQ-1)) ? '0 : gid + IDW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            id_q  <= '0;
            dat_q <= '0;
            ptr_q <= '0;
        end else if (flush) begin
            // Data/id are left as-is; only the valid bits matter downstream.
            vld_q <= '0;
        end else if (!stall) begin
            vld_q[0] <= any_gnt;
            if (any_gnt) begin
                id_q[0]  <= gid;
                dat_q[0] <= sel_dat;
            end
            for (int j = 1; j < DELAY; j++) begin
                vld_q[j] <= vld_q[j-1];
                id_q[j]  <= id_q[j-1];
                dat_q[j] <= dat_q[j-1];
            end
            ptr_q <= ptr_d;
        end
    end

    assign odat_vld = vld_q[DELAY-1];
    assign odat     = dat_q[DELAY-1];
    assign oid      = id_q[DELAY-1];
    assign busy     = |vld_q;

endmodule

// File: tb/tb_s_pl_arb_nclk.sv
// ---------------------------------------------------------------------------
// tb_s_pl_arb_nclk
// Directed bench for s_pl_arb_nclk (NREQ=4, SIZE=8, DELAY=3). Each record is
// one clock cycle: inputs are applied 1 time unit after the rising edge and
// outputs are compared on the following falling edge.
// ---------------------------------------------------------------------------
module tb_s_pl_arb_nclk;

    localparam int NREQ  = 4;
    localparam int SIZE  = 8;
    localparam int DELAY = 3;

    logic                 clk;
    logic                 rst, stall, flush;
    logic [NREQ-1:0]      req_vld;
    logic [NREQ*SIZE-1:0] req_dat;
    logic [NREQ-1:0]      req_gnt;
    logic                 odat_vld;
    logic [SIZE-1:0]      odat;
    logic [1:0]           oid;
    logic                 busy;

    int n_chk = 0;
    int n_err = 0;

    s_pl_arb_nclk #(.NREQ(NREQ), .SIZE(SIZE), .DELAY(DELAY)) dut (
        .clk      (clk),
        .rst      (rst),
        .stall    (stall),
        .flush    (flush),
        .req_vld  (req_vld),
        .req_dat  (req_dat),
        .req_gnt  (req_gnt),
        .odat_vld (odat_vld),
        .odat     (odat),
        .oid      (oid),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // dchk=1: also compare odat/oid (otherwise they are don't-care).
    typedef struct {
        logic        rst, stall, flush;
        logic [3:0]  vld;
        logic [31:0] dat;
        logic [3:0]  gnt;
        logic        ovld;
        logic        dchk;
        logic [7:0]  odat;
        logic [1:0]  oid;
        logic        busy;
    } vec_t;

    vec_t tbl[27];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run(input vec_t v, input string tag);
        @(posedge clk);
        #1;
        rst     = v.rst;
        stall   = v.stall;
        flush   = v.flush;
        req_vld = v.vld;
        req_dat = v.dat;
        @(negedge clk);
        check({tag, ".gnt"},  32'(req_gnt),  32'(v.gnt));
        check({tag, ".ovld"}, 32'(odat_vld), 32'(v.ovld));
        check({tag, ".busy"}, 32'(busy),     32'(v.busy));
        if (v.dchk) begin
            check({tag, ".odat"}, 32'(odat), 32'(v.odat));
            check({tag, ".oid"},  32'(oid),  32'(v.oid));
        end
    endtask

    // Shorthand: normal cycle with no control asserted.
    function automatic vec_t nv(input logic [3:0] vld, input logic [31:0] dat,
                                input logic [3:0] gnt, input logic ovld, input logic dchk,
                                input logic [7:0] od, input logic [1:0] id, input logic bsy);
        vec_t v;
        v = '{1'b0, 1'b0, 1'b0, vld, dat, gnt, ovld, dchk, od, id, bsy};
        return v;
    endfunction

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        req_vld = 4'hF; req_dat = '0;

        // Reset held two cycles with all requests up: no grant, pipe empty.
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 4'hF, 32'h0, 4'h0, 1'b0, 1'b1, 8'h00, 2'd0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 4'hF, 32'h0, 4'h0, 1'b0, 1'b1, 8'h00, 2'd0, 1'b0};
        // Single request from 2, exits three cycles later for one cycle.
        tbl[2]  = nv(4'b0100, 32'h00A50000, 4'b0100, 0, 0, 8'h00, 2'd0, 0);
        tbl[3]  = nv(4'b0000, 32'h0,        4'b0000, 0, 0, 8'h00, 2'd0, 1);
        tbl[4]  = nv(4'b0000, 32'h0,        4'b0000, 0, 0, 8'h00, 2'd0, 1);
        tbl[5]  = nv(4'b0000, 32'h0,        4'b0000, 1, 1, 8'hA5, 2'd2, 1);
        // Re-reset so round robin starts from pointer 0.
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0};
        // All four requesting for 8 cycles: 0,1,2,3,0,1,2,3 back-to-back.
        tbl[7]  = nv(4'hF, 32'h13121110, 4'b0001, 0, 0, 8'h00, 2'd0, 0);
        tbl[8]  = nv(4'hF, 32'h13121110, 4'b0010, 0, 0, 8'h00, 2'd0, 1);
        tbl[9]  = nv(4'hF, 32'h13121110, 4'b0100, 0, 0, 8'h00, 2'd0, 1);
        tbl[10] = nv(4'hF, 32'h13121110, 4'b1000, 1, 1, 8'h10, 2'd0, 1);
        tbl[11] = nv(4'hF, 32'h13121110, 4'b0001, 1, 1, 8'h11, 2'd1, 1);
        tbl[12] = nv(4'hF, 32'h13121110, 4'b0010, 1, 1, 8'h12, 2'd2, 1);
        tbl[13] = nv(4'hF, 32'h13121110, 4'b0100, 1, 1, 8'h13, 2'd3, 1);
        tbl[14] = nv(4'hF, 32'h13121110, 4'b1000, 1, 1, 8'h10, 2'd0, 1);
        tbl[15] = nv(4'h0, 32'h0,        4'b0000, 1, 1, 8'h11, 2'd1, 1);
        tbl[16] = nv(4'h0, 32'h0,        4'b0000, 1, 1, 8'h12, 2'd2, 1);
        tbl[17] = nv(4'h0, 32'h0,        4'b0000, 1, 1, 8'h13, 2'd3, 1);
        // Stream three words (ptr=0), then stall two cycles while the first exits.
        tbl[18] = nv(4'b0111, 32'h00C2B1A0, 4'b0001, 0, 0, 8'h00, 2'd0, 0);
        tbl[19] = nv(4'b0110, 32'h00C2B1A0, 4'b0010, 0, 0, 8'h00, 2'd0, 1);
        tbl[20] = nv(4'b0100, 32'h00C2B1A0, 4'b0100, 0, 0, 8'h00, 2'd0, 1);
        tbl[21] = '{1'b0, 1'b1, 1'b0, 4'b1000, 32'hD3000000, 4'h0, 1'b1, 1'b1, 8'hA0, 2'd0, 1'b1};
        tbl[22] = '{1'b0, 1'b1, 1'b0, 4'b1000, 32'hD3000000, 4'h0, 1'b1, 1'b1, 8'hA0, 2'd0, 1'b1};
        tbl[23] = nv(4'h0, 32'h0, 4'b0000, 1, 1, 8'hA0, 2'd0, 1);
        tbl[24] = nv(4'h0, 32'h0, 4'b0000, 1, 1, 8'hB1, 2'd1, 1);
        tbl[25] = nv(4'h0, 32'h0, 4'b0000, 1, 1, 8'hC2, 2'd2, 1);
        tbl[26] = nv(4'h0, 32'h0, 4'b0000, 0, 0, 8'h00, 2'd0, 0);

        foreach (tbl[i]) run(tbl[i], $sformatf("vec%0d", i));

        // Flush with stall and all requests up (ptr=3): grants 3,0,1 then kill.
        run(nv(4'hF, 32'h44332211, 4'b1000, 0, 0, 8'h00, 2'd0, 0), "fl0");
        run(nv(4'hF, 32'h44332211, 4'b0001, 0, 0, 8'h00, 2'd0, 1), "fl1");
        run(nv(4'hF, 32'h44332211, 4'b0010, 0, 0, 8'h00, 2'd0, 1), "fl2");
        v = '{1'b0, 1'b1, 1'b1, 4'hF, 32'h44332211, 4'h0, 1'b1, 1'b1, 8'h44, 2'd3, 1'b1};
        run(v, "fl3");
        for (int k = 0; k < 4; k++)
            run(nv(4'h0, 32'h0, 4'b0000, 0, 0, 8'h00, 2'd0, 0), $sformatf("fl_idle%0d", k));
        // Pointer held across flush: next winner is 2.
        run(nv(4'hF, 32'h44332211, 4'b0100, 0, 0, 8'h00, 2'd0, 0), "fl_ptr");
        run(nv(4'h0, 32'h0, 4'b0000, 0, 0, 8'h00, 2'd0, 1), "fl_p1");
        run(nv(4'h0, 32'h0, 4'b0000, 0, 0, 8'h00, 2'd0, 1), "fl_p2");
        run(nv(4'h0, 32'h0, 4'b0000, 1, 1, 8'h33, 2'd2, 1), "fl_p3");
        run(nv(4'h0, 32'h0, 4'b0000, 0, 0, 8'h00, 2'd0, 0), "fl_p4");

        // Wrap (ptr=3, req 1001): 3,0,3, then synchronous reset mid-stream.
        run(nv(4'b1001, 32'hD30000D0, 4'b1000, 0, 0, 8'h00, 2'd0, 0), "wr0");
        run(nv(4'b1001, 32'hD30000D0, 4'b0001, 0, 0, 8'h00, 2'd0, 1), "wr1");
        run(nv(4'b1001, 32'hD30000D0, 4'b1000, 0, 0, 8'h00, 2'd0, 1), "wr2");
        v = '{1'b1, 1'b0, 1'b0, 4'b1001, 32'hD30000D0, 4'h0, 1'b1, 1'b1, 8'hD3, 2'd3, 1'b1};
        run(v, "wr_rst");
        run(nv(4'h0, 32'h0, 4'b0000, 0, 1, 8'h00, 2'd0, 0), "wr_post");
        // Pointer back at 0 after reset.
        run(nv(4'hF, 32'h0, 4'b0001, 0, 0, 8'h00, 2'd0, 0), "wr_ptr0");
        run(nv(4'h0, 32'h0, 4'b0000, 0, 0, 8'h00, 2'd0, 1), "wr_end");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
